// File: rtl/serial_tx_pkg.sv
// Shared types and default parameters for the bit-serial frame transmitter.
// Frame = fixed preamble, then payload MSB-first, then an idle gap.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int         DEF_DATA_W   = 8;
    localparam int         DEF_PRE_W    = 3;
    localparam logic [2:0] DEF_PREAMBLE = 3'b101;
    localparam int         DEF_GAP      = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB-first, zero-filling on shift.
// Once every loaded bit has been shifted out the serial output rests at 0.
module piso_shift_reg #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_serial
);

    logic [W-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[W-2:0], 1'b0};
        end
    end

    assign o_serial = r_sr[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: accepts one payload word per valid/ready handshake
// and sends preamble + payload one bit per clock, then holds the line low for GAP cycles.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               PRE_W    = DEF_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE = DEF_PREAMBLE,
    parameter int               GAP      = DEF_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              data_out,
    output logic              tx_active,
    output logic              frame_done,
    output state_t            dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // The source holds in_valid/in_data stable until then; in_ready only rises in IDLE.

    localparam int SR_W  = PRE_W + DATA_W;
    localparam int CNT_W = $clog2(max3(PRE_W, DATA_W, GAP) + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_tx_active;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_shift;
    logic             w_serial;

    assign w_accept = in_valid && r_in_ready && (r_state == S_IDLE);
    assign w_shift  = (r_state == S_PRE) || (r_state == S_DATA);

    piso_shift_reg #(
        .W (SR_W)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_shift  (w_shift),
        .i_data   ({PREAMBLE, in_data}),
        .o_serial (w_serial)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_tx_active  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_PRE;
                        r_cnt       <= PRE_LAST;
                        r_in_ready  <= 1'b0;
                        r_tx_active <= 1'b1;
                    end else begin
                        r_in_ready  <= 1'b1;
                        r_tx_active <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DATA;
                        r_cnt   <= DATA_LAST;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_tx_active  <= 1'b0;
                        r_frame_done <= 1'b1;
                        // With no gap the next word can be taken on the very next edge.
                        if (GAP > 0) begin
                            r_state <= S_GAP;
                            r_cnt   <= GAP_LAST;
                        end else begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_in_ready   <= 1'b0;
                    r_tx_active  <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign data_out   = w_serial;
    assign tx_active  = r_tx_active;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule
